// File: rtl/inout_half_duplex_port.sv
// rtl/inout_half_duplex_port.sv - clocked half-duplex pad endpoint with turnaround gaps and contention flag
module inout_half_duplex_port #(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] pad,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_last,
    output logic             tx_ready,
    input  logic             rx_en,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             drive_en,
    output logic             contention
);

    generate
        if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
            $error("inout_half_duplex_port: TURNAROUND must be within 1..15");
        end
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("inout_half_duplex_port: WIDTH must be within 1..32");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_LISTEN = 3'd0,
        ST_TA_OUT = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TA_IN  = 3'd4
    } state_t;

    // Last counter value of a turnaround window; the window is TURNAROUND cycles long.
    localparam logic [3:0] TA_LAST = 4'(TURNAROUND - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             oe_q, oe_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             contention_q, contention_d;
    logic             mismatch;

    // The pad is only ever driven from registered state, so it never glitches.
    assign pad = oe_q ? dout_q : {WIDTH{1'bz}};

    assign tx_ready   = (state_q == ST_DRIVE);
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign drive_en   = oe_q;
    assign contention = contention_q;

    // Compare the pad against our own value; the else branch also catches x/z bits in simulation.
    always_comb begin
        mismatch = 1'b0;
        if (pad == dout_q) begin
            mismatch = 1'b0;
        end else begin
            mismatch = 1'b1;
        end
    end

    // Next-state logic for the direction FSM, the turnaround counter and the datapath registers.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        oe_d         = oe_q;
        dout_d       = dout_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        contention_d = contention_q | (oe_q & mismatch);

        case (state_q)
            ST_LISTEN: begin
                if (tx_valid) begin
                    // Transmit wins over receive; the sample of this cycle is dropped.
                    state_d      = ST_TA_OUT;
                    cnt_d        = 4'd0;
                    contention_d = 1'b0;
                end else if (rx_en) begin
                    rx_data_d  = pad;
                    rx_valid_d = 1'b1;
                end
            end

            ST_TA_OUT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == TA_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = 4'd0;
                end
            end

            ST_DRIVE: begin
                // A stalled source leaves oe and the last beat untouched.
                if (tx_valid) begin
                    dout_d = tx_data;
                    oe_d   = 1'b1;
                    if (tx_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                oe_d    = 1'b0;
                cnt_d   = 4'd0;
                state_d = ST_TA_IN;
            end

            ST_TA_IN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == TA_LAST) begin
                    state_d = ST_LISTEN;
                    cnt_d   = 4'd0;
                end
            end

            default: begin
                state_d = ST_LISTEN;
                cnt_d   = 4'd0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LISTEN;
            cnt_q        <= 4'd0;
            oe_q         <= 1'b0;
            dout_q       <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            contention_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            oe_q         <= oe_d;
            dout_q       <= dout_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            contention_q <= contention_d;
        end
    end

endmodule

// File: tb/tb_inout_half_duplex_port.sv
// tb/tb_inout_half_duplex_port.sv - scoreboard bench for inout_half_duplex_port
module tb_inout_half_duplex_port;

    localparam int W  = 8;
    localparam int TA = 2;

    logic         clk = 1'b0;
    logic         rst;
    wire  [W-1:0] pad;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_last;
    logic         tx_ready;
    logic         rx_en;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         drive_en;
    logic         contention;

    logic         peer_oe;
    logic [W-1:0] peer_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_tx[$];
    logic [W-1:0] exp_rx[$];
    logic         acc_pending = 1'b0;
    logic [W-1:0] mon_exp;

    assign pad = peer_oe ? peer_data : {W{1'bz}};

    inout_half_duplex_port #(.WIDTH(W), .TURNAROUND(TA)) dut (
        .clk        (clk),
        .rst        (rst),
        .pad        (pad),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .rx_en      (rx_en),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .drive_en   (drive_en),
        .contention (contention)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 32) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL %s: tx_ready timeout after %0d cycles, required within 32", name, n);
        end
    endtask

    // Monitor: pops expected beats/samples whenever the DUT presents them.
    always @(negedge clk) begin
        if (acc_pending) begin
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected_accept: pad 0x%0h with no expected beat", pad);
            end else begin
                mon_exp = exp_tx.pop_front();
                check("pad_beat", pad, mon_exp);
                check("drive_en_beat", drive_en, 1);
            end
        end
        if (rx_valid) begin
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: rx_data 0x%0h with no expected sample", rx_data);
            end else begin
                mon_exp = exp_rx.pop_front();
                check("rx_data", rx_data, mon_exp);
            end
        end
        acc_pending = tx_valid && tx_ready && !rst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        rx_en = 1'b0; peer_oe = 1'b0; peer_data = '0;
        step(); step();
        neg();
        check("rst_drive_en", drive_en, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_contention", contention, 0);
        step(); rst = 1'b0;
        neg();

        // Basic burst 0x11, 0x22, 0x33(last), request in period n
        step(); tx_valid = 1'b1; tx_data = 8'h11; exp_tx.push_back(8'h11);
        neg(); check("ready_n", tx_ready, 0);
        step(); neg(); check("ready_n1", tx_ready, 0);
        step(); neg(); check("ready_n2", tx_ready, 0);
        step(); neg(); check("ready_n3", tx_ready, 1); check("released_before_accept", drive_en, 0);
        step(); tx_data = 8'h22; exp_tx.push_back(8'h22);
        neg(); check("ready_n4", tx_ready, 1);
        step(); tx_data = 8'h33; tx_last = 1'b1; exp_tx.push_back(8'h33);
        neg(); check("ready_n5", tx_ready, 1);
        step(); tx_valid = 1'b0; tx_last = 1'b0;
        neg(); check("hold_ready", tx_ready, 0); check("hold_drive_en", drive_en, 1);

        // Receive: peer starts driving in TA_IN; sampling begins in LISTEN
        step(); peer_oe = 1'b1; peer_data = 8'h5A; rx_en = 1'b1; exp_rx.push_back(8'h5A);
        neg(); check("ta_in0_drive_en", drive_en, 0); check("ta_in0_ready", tx_ready, 0);
        check("ta_in0_rx_valid", rx_valid, 0);
        step(); neg(); check("ta_in1_ready", tx_ready, 0); check("ta_in1_rx_valid", rx_valid, 0);
        step(); neg(); check("listen_rx_valid0", rx_valid, 0); check("listen_ready", tx_ready, 0);
        step(); peer_data = 8'hC3; exp_rx.push_back(8'hC3);
        neg(); check("rx_valid_5a", rx_valid, 1);
        step(); rx_en = 1'b0;
        neg(); check("rx_valid_c3", rx_valid, 1);
        step(); neg(); check("rx_en_off_0", rx_valid, 0);
        step(); peer_oe = 1'b0;
        neg(); check("rx_en_off_1", rx_valid, 0);

        // Stall mid-burst after 0x44
        step(); tx_valid = 1'b1; tx_data = 8'h44; tx_last = 1'b0; exp_tx.push_back(8'h44);
        wait_ready("stall_ready");
        step(); tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("stall_pad", pad, 8'h44);
            check("stall_drive_en", drive_en, 1);
            check("stall_ready", tx_ready, 1);
            step();
        end
        tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1; exp_tx.push_back(8'h55);
        neg(); check("pad_before_55", pad, 8'h44);
        step(); tx_valid = 1'b0; tx_last = 1'b0;
        neg(); check("stall_hold_drive_en", drive_en, 1);
        repeat (3) step();

        // Contention: peer drives 0xFF against 0x0F
        tx_valid = 1'b1; tx_data = 8'h0F; exp_tx.push_back(8'h0F);
        wait_ready("cont_ready");
        step(); tx_valid = 1'b0;
        neg(); check("cont_clear_before", contention, 0);
        step(); peer_oe = 1'b1; peer_data = 8'hFF;
        neg(); check("cont_not_yet", contention, 0);
        step(); peer_oe = 1'b0; tx_valid = 1'b1; tx_data = 8'h01; tx_last = 1'b1; exp_tx.push_back(8'h01);
        neg(); check("cont_set", contention, 1);
        step(); tx_valid = 1'b0; tx_last = 1'b0;
        neg(); check("cont_hold", contention, 1);
        step(); neg(); check("cont_ta_in0", contention, 1); check("cont_ta_in0_oe", drive_en, 0);
        step(); neg(); check("cont_ta_in1", contention, 1);

        // Priority: tx_valid and rx_en together in LISTEN
        step(); tx_valid = 1'b1; rx_en = 1'b1; tx_data = 8'h77; tx_last = 1'b1; exp_tx.push_back(8'h77);
        neg(); check("cont_listen", contention, 1);
        step(); rx_en = 1'b0;
        neg(); check("prio_rx_valid", rx_valid, 0); check("cont_cleared_ta_out", contention, 0);
        check("prio_ready", tx_ready, 0);
        wait_ready("prio_ready_wait");
        step(); tx_valid = 1'b0; tx_last = 1'b0;
        neg(); check("prio_hold_drive_en", drive_en, 1);
        repeat (3) step();

        // Reset mid-burst while 0xA5 is on the pad
        tx_valid = 1'b1; tx_data = 8'hA5; exp_tx.push_back(8'hA5);
        wait_ready("rst_burst_ready");
        step(); tx_valid = 1'b0;
        neg(); check("pre_rst_drive_en", drive_en, 1);
        step(); rst = 1'b1;
        neg(); check("rst_not_sampled_drive_en", drive_en, 1);
        step(); rst = 1'b0; rx_en = 1'b1; peer_oe = 1'b1; peer_data = 8'h3C; exp_rx.push_back(8'h3C);
        neg();
        check("midrst_drive_en", drive_en, 0);
        check("midrst_ready", tx_ready, 0);
        check("midrst_contention", contention, 0);
        check("midrst_rx_valid", rx_valid, 0);
        step(); rx_en = 1'b0;
        neg(); check("midrst_listen_rx", rx_valid, 1);
        step(); peer_oe = 1'b0;
        neg(); check("midrst_rx_done", rx_valid, 0);

        repeat (3) step();
        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_rx_drained", exp_rx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
